// File: rtl/regfile_scoreboard.sv
// Register file with two bypassed read ports, one write-back port and a
// per-register pending-write scoreboard. Optional debug port/counter: REGFILE_SCOREBOARD_DBG_EN.
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] rdv,
   input  logic            reg_wen,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic            issue_wr,
   input  logic            issue_use_rs1,
   input  logic            issue_use_rs2,
   output logic            issue_ready,
   input  logic            flush,
`ifdef REGFILE_SCOREBOARD_DBG_EN
   input  logic [AW-1:0]   dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata,
   output logic [31:0]     wr_count,
`endif
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0] mem_q [NREGS];
   logic [XLEN-1:0] mem_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      busy_count_q, busy_count_d;
   logic             wr_en;
   logic             hazard;

   function automatic logic writable(input logic [AW-1:0] idx);
      return !((ZERO_REG != 0) && (idx == '0));
   endfunction

   assign wr_en = reg_wen && writable(rd);

   // A write-back in the same cycle both forwards its data and satisfies the dependency.
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (writable(rs1)) rs1_data = (reg_wen && rd == rs1) ? rdv : mem_q[rs1];
      if (writable(rs2)) rs2_data = (reg_wen && rd == rs2) ? rdv : mem_q[rs2];
      rs1_busy = busy_q[rs1] && !(reg_wen && rd == rs1);
      rs2_busy = busy_q[rs2] && !(reg_wen && rd == rs2);
   end

   // Handshake: an instruction issues on any cycle where issue_valid && issue_ready;
   // issue_ready is purely combinational and never depends on a future cycle.
   always_comb begin
      hazard = (issue_use_rs1 && rs1_busy) || (issue_use_rs2 && rs2_busy) ||
               (issue_wr && busy_q[issue_rd] && !(reg_wen && rd == issue_rd));
      issue_ready = issue_valid && !hazard && !flush;
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[rd] = rdv;
   end

   // Set after clear so a new producer wins over the retiring one on the same index.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (reg_wen) busy_d[rd] = 1'b0;
         if (issue_ready && issue_wr && writable(issue_rd)) busy_d[issue_rd] = 1'b1;
      end
      busy_count_d = '0;
      for (int i = 0; i < NREGS; i++) busy_count_d = busy_count_d + (AW+1)'(busy_d[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         mem_q        <= mem_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign busy_count = busy_count_q;

`ifdef REGFILE_SCOREBOARD_DBG_EN
   logic [31:0] wr_count_q, wr_count_d;

   assign wr_count_d = wr_count_q + (wr_en ? 32'd1 : 32'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_count_q <= '0;
      else        wr_count_q <= wr_count_d;
   end

   assign wr_count  = wr_count_q;
   assign dbg_rdata = mem_q[dbg_raddr];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard: per-cycle table of inputs and
// expected pre-edge outputs, plus hand sequences for async reset and debug port.
module tb_regfile_scoreboard;
   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk, rst_n;
   logic [AW-1:0]   rs1, rs2, rd, issue_rd;
   logic [XLEN-1:0] rs1_data, rs2_data, rdv;
   logic            rs1_busy, rs2_busy, reg_wen;
   logic            issue_valid, issue_wr, issue_use_rs1, issue_use_rs2, issue_ready, flush;
   logic [AW:0]     busy_count;
`ifdef REGFILE_SCOREBOARD_DBG_EN
   logic [AW-1:0]   dbg_raddr;
   logic [XLEN-1:0] dbg_rdata;
   logic [31:0]     wr_count;
`endif

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(32), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rd(rd), .rdv(rdv), .reg_wen(reg_wen),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
      .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
      .issue_ready(issue_ready), .flush(flush),
`ifdef REGFILE_SCOREBOARD_DBG_EN
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .wr_count(wr_count),
`endif
      .busy_count(busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0]   rs1, rs2, rd, ird;
      logic [XLEN-1:0] rdv;
      logic            wen, iv, iwr, u1, u2, fl;
      logic [XLEN-1:0] e1d, e2d;
      logic            e1b, e2b, erdy;
      logic [AW:0]     ecnt;
   } vec_t;

   vec_t vecs[$];
   int   pass_cnt = 0;
   int   total    = 0;

   task automatic add_vec(input int r1, input int r2, input int w, input int d, input logic [XLEN-1:0] v,
                          input int iv, input int ird, input int iwr, input int u1, input int u2, input int fl,
                          input logic [XLEN-1:0] e1d, input logic [XLEN-1:0] e2d,
                          input int e1b, input int e2b, input int erdy, input int ecnt);
      vec_t t;
      t.rs1 = AW'(r1); t.rs2 = AW'(r2); t.wen = w[0]; t.rd = AW'(d); t.rdv = v;
      t.iv = iv[0]; t.ird = AW'(ird); t.iwr = iwr[0]; t.u1 = u1[0]; t.u2 = u2[0]; t.fl = fl[0];
      t.e1d = e1d; t.e2d = e2d; t.e1b = e1b[0]; t.e2b = e2b[0]; t.erdy = erdy[0]; t.ecnt = (AW+1)'(ecnt);
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive_idle();
      rs1 = '0; rs2 = '0; rd = '0; rdv = '0; reg_wen = 0;
      issue_valid = 0; issue_rd = '0; issue_wr = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; flush = 0;
`ifdef REGFILE_SCOREBOARD_DBG_EN
      dbg_raddr = '0;
`endif
   endtask

   initial begin
      //       rs1 rs2 wen rd rdv           iv ird iwr u1 u2 fl  e1d           e2d           e1b e2b rdy cnt
      add_vec(0,  0,  0,  0, 32'h0,        0, 0,  0,  0, 0, 0,  32'h0,        32'h0,        0,  0,  0,  0);
      add_vec(5,  0,  1,  5, 32'hDEAEEFFA, 0, 0,  0,  0, 0, 0,  32'hDEAEEFFA, 32'h0,        0,  0,  0,  0);
      add_vec(5,  0,  0,  0, 32'h0,        0, 0,  0,  0, 0, 0,  32'hDEAEEFFA, 32'h0,        0,  0,  0,  0);
      add_vec(0,  0,  1,  0, 32'h12345678, 1, 0,  1,  0, 0, 0,  32'h0,        32'h0,        0,  0,  1,  0);
      add_vec(0,  0,  0,  0, 32'h0,        0, 0,  0,  0, 0, 0,  32'h0,        32'h0,        0,  0,  0,  0);
      add_vec(5,  0,  0,  0, 32'h0,        1, 10, 1,  0, 0, 0,  32'hDEAEEFFA, 32'h0,        0,  0,  1,  0);
      add_vec(10, 0,  0,  0, 32'h0,        1, 0,  0,  1, 0, 0,  32'h0,        32'h0,        1,  0,  0,  1);
      add_vec(10, 0,  1, 10, 32'hCAFECAFE, 1, 0,  0,  1, 0, 0,  32'hCAFECAFE, 32'h0,        0,  0,  1,  1);
      add_vec(0,  0,  0,  0, 32'h0,        1, 7,  1,  0, 0, 0,  32'h0,        32'h0,        0,  0,  1,  0);
      add_vec(7,  0,  1,  7, 32'h77777777, 1, 7,  1,  0, 0, 0,  32'h77777777, 32'h0,        0,  0,  1,  1);
      add_vec(7,  0,  0,  0, 32'h0,        0, 0,  0,  0, 0, 0,  32'h77777777, 32'h0,        1,  0,  0,  1);
      add_vec(0,  7,  0,  0, 32'h0,        1, 7,  1,  0, 0, 0,  32'h0,        32'h77777777, 0,  1,  0,  1);
      add_vec(7,  0,  1,  7, 32'h1,        0, 0,  0,  0, 0, 0,  32'h1,        32'h0,        0,  0,  0,  1);
      add_vec(0,  0,  0,  0, 32'h0,        1, 3,  1,  0, 0, 0,  32'h0,        32'h0,        0,  0,  1,  0);
      add_vec(0,  0,  0,  0, 32'h0,        1, 4,  1,  0, 0, 0,  32'h0,        32'h0,        0,  0,  1,  1);
      add_vec(0,  0,  0,  0, 32'h0,        1, 6,  1,  0, 0, 0,  32'h0,        32'h0,        0,  0,  1,  2);
      add_vec(3,  0,  0,  0, 32'h0,        1, 8,  1,  0, 0, 1,  32'h0,        32'h0,        1,  0,  0,  3);
      add_vec(3,  0,  0,  0, 32'h0,        0, 0,  0,  0, 0, 0,  32'h0,        32'h0,        0,  0,  0,  0);
      add_vec(5, 12,  1, 12, 32'hABCD0123, 0, 0,  0,  0, 0, 0,  32'hDEAEEFFA, 32'hABCD0123, 0,  0,  0,  0);
      add_vec(5, 12,  0,  0, 32'h0,        1, 12, 1,  0, 0, 0,  32'hDEAEEFFA, 32'hABCD0123, 0,  0,  1,  0);
      add_vec(5, 12,  0,  0, 32'h0,        1, 0,  0,  0, 1, 0,  32'hDEAEEFFA, 32'hABCD0123, 0,  1,  0,  1);
      add_vec(0, 12,  0,  0, 32'h0,        0, 0,  0,  0, 0, 1,  32'h0,        32'hABCD0123, 0,  1,  0,  1);
      add_vec(0, 12,  0,  0, 32'h0,        0, 0,  0,  0, 0, 0,  32'h0,        32'hABCD0123, 0,  0,  0,  0);

      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; reg_wen = vecs[i].wen; rd = vecs[i].rd; rdv = vecs[i].rdv;
         issue_valid = vecs[i].iv; issue_rd = vecs[i].ird; issue_wr = vecs[i].iwr;
         issue_use_rs1 = vecs[i].u1; issue_use_rs2 = vecs[i].u2; flush = vecs[i].fl;
         #2;
         check($sformatf("v%0d rs1_data", i), rs1_data, vecs[i].e1d);
         check($sformatf("v%0d rs2_data", i), rs2_data, vecs[i].e2d);
         check($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(vecs[i].e1b));
         check($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(vecs[i].e2b));
         check($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(vecs[i].erdy));
         check($sformatf("v%0d busy_count", i), 32'(busy_count), 32'(vecs[i].ecnt));
      end

      // Make x9 busy, then pull reset low in the middle of a clock phase.
      @(negedge clk);
      drive_idle();
      issue_valid = 1; issue_wr = 1; issue_rd = 5'd9;
      @(negedge clk);
      drive_idle();
      rs1 = 5'd5; rs2 = 5'd9;
      #1;
      check("pre_rst busy_count", 32'(busy_count), 32'd1);
      check("pre_rst rs1_data", rs1_data, 32'hDEAEEFFA);
      check("pre_rst rs2_busy", 32'(rs2_busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst rs1_data", rs1_data, 32'h0);
      check("async_rst rs2_busy", 32'(rs2_busy), 32'd0);
      check("async_rst busy_count", 32'(busy_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst rs1_data", rs1_data, 32'h0);

`ifdef REGFILE_SCOREBOARD_DBG_EN
      @(negedge clk);
      reg_wen = 1; rd = 5'd9; rdv = 32'hA5A5A5A5; dbg_raddr = 5'd9;
      #1;
      check("dbg no bypass", dbg_rdata, 32'h0);
      check("wr_count start", wr_count, 32'd0);
      @(negedge clk);
      reg_wen = 1; rd = 5'd0; rdv = 32'hFFFFFFFF;
      #1;
      check("dbg_rdata x9", dbg_rdata, 32'hA5A5A5A5);
      check("wr_count one", wr_count, 32'd1);
      @(negedge clk);
      drive_idle();
      #1;
      check("wr_count x0 excluded", wr_count, 32'd1);
      check("dbg_rdata x0", dbg_rdata, 32'h0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file with a per-register pending-write scoreboard. It is the next generation of the core's register file and targets pipelined issue.
- Two combinational read ports with write-through bypass.
- One synchronous write-back port.
- Issue port marks destination registers busy.
- Produces RAW/WAW hazard and ready signals so decode can stall without external tracking.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
AW, $clog2(NREGS), register index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1  in  AW  read port 1 index
rs2  in  AW  read port 2 index
rs1_data  out  XLEN  read port 1 data
rs2_data  out  XLEN  read port 2 data
rs1_busy  out  1  rs1 has a pending write not satisfied this cycle
rs2_busy  out  1  same for rs2
rd  in  AW  write-back index
rdv  in  XLEN  write-back data
reg_wen  in  1  write-back enable
issue_valid  in  1  decode requests issue of an instruction
issue_rd  in  AW  destination of issuing instruction
issue_wr  in  1  issuing instruction writes issue_rd
issue_use_rs1  in  1  issuing instruction reads rs1
issue_use_rs2  in  1  issuing instruction reads rs2
issue_ready  out  1  issue accepted this cycle (no hazard)
flush  in  1  synchronous clear of all busy bits
busy_count  out  AW+1  number of busy registers

Behaviour:
- Reset (rst_n=0, async): all registers = 0, all busy bits = 0, busy_count = 0. Outputs follow combinationally; with rs1=rs2=0, rs*_data = 0, rs*_busy = 0, issue_ready = issue_valid.
- Write: on rising clk, if reg_wen and not (ZERO_REG and rd==0), then mem[rd] <= rdv.
- Read: combinational, zero latency. rsN_data = rdv if reg_wen and rd==rsN and rd writable; else mem[rsN]. Index 0 reads 0 when ZERO_REG=1.
- Busy: rsN_busy = busy[rsN] and not (reg_wen and rd==rsN). Same-cycle write-back satisfies the dependency.
- Hazard = (issue_use_rs1 and rs1_busy) or (issue_use_rs2 and rs2_busy) or (issue_wr and busy[issue_rd] and not (reg_wen and rd==issue_rd)).
- issue_ready = issue_valid and not hazard and not flush.
- Busy update, rising clk, in priority order:
  - flush: all bits 0, issue ignored.
  - Issue set: if issue_ready and issue_wr and issue_rd writable, busy[issue_rd] <= 1. Set beats a same-cycle clear of the same index (new producer).
  - Write-back clear: if reg_wen, busy[rd] <= 0.
- Write-back to a non-busy register is legal: data is written and the busy bit stays 0.
- busy_count: registered, equals popcount of busy bits after each edge. Range 0..NREGS-1 with ZERO_REG=1, 0..NREGS with ZERO_REG=0.
- ZERO_REG=0: index 0 is an ordinary register (writable, can be busy).
- Reset asserted mid-operation clears everything immediately regardless of clk. Release is synchronised externally.

Optional Feature:
Macro: REGFILE_SCOREBOARD_DBG_EN
- Defined:
  - Adds ports dbg_raddr (in, AW) and dbg_rdata (out, XLEN): third combinational read port with no bypass (returns stored value).
  - Adds wr_count (out, 32): counts accepted writes (x0 writes excluded when ZERO_REG=1), reset 0, wraps at 2^32.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then write 0xDEAEEFFA to x5, next cycle rs1=5 -> rs1_data=0xDEAEEFFA, rs1_busy=0, busy_count=0.
2. Write 0x12345678 to x0 (ZERO_REG=1), also issue_rd=0 with issue_wr=1 -> x0 reads 0x00000000, busy_count stays 0, issue_ready=1.
3. Issue rd=10 (accepted); next cycle issue with rs1=10, issue_use_rs1=1 -> issue_ready=0, rs1_busy=1. Then reg_wen rd=10 rdv=0xCAFECAFE the same cycle -> rs1_data=0xCAFECAFE, rs1_busy=0, issue_ready=1.
4. x7 busy; same cycle reg_wen rd=7 and an accepted issue with issue_rd=7 -> after edge busy[7]=1, busy_count=1, mem[7] updated.
5. Issue rd=3, 4, 6 on three cycles -> busy_count=3. Assert flush with issue_valid=1 -> issue_ready=0, busy_count=0 next cycle. Then assert rst_n=0 mid-cycle -> all reads 0 immediately.
6. With REGFILE_SCOREBOARD_DBG_EN: write x9=0xA5A5A5A5 and x0, dbg_raddr=9 -> dbg_rdata=0xA5A5A5A5, wr_count=1.
